// File: rtl/synth_mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// State encodings and requester indices used by the arbiter and its bench.
package synth_mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/synth_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// clr together with inc loads 1, so a fresh run can start counting in the same cycle.
module synth_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/synth_mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between a CPU and a debug requester,
// with a bounded grant lock and 1-cycle read-return routing.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ARB_IDLE  | plain round-robin between the two requesters
// ARB_LOCK0 | requester 0 holds the port while it keeps requesting
// ARB_LOCK1 | requester 1 holds the port while it keeps requesting
module synth_mem_port_arbiter
  import synth_mem_port_arbiter_pkg::*;
#(
  parameter int N        = 32,
  parameter int LOCK_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [N-1:0]     addr0,
  input  logic [N-1:0]     addr1,
  input  logic [N-1:0]     wdata0,
  input  logic [N-1:0]     wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [N-1:0]     rdata0,
  output logic [N-1:0]     rdata1,
  output logic             mem_wr_ena,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_din,
  input  logic [N-1:0]     mem_dout,
  output logic [CNT_W-1:0] contention_cnt
);

  localparam int LEN_W = $clog2(LOCK_MAX);

  arb_state_e       state_q, state_d;
  arb_state_e       lock_tgt;
  logic             last_winner_q;
  logic [1:0]       rd_pending_q;
  logic [LEN_W-1:0] lock_len;
  logic             len_clr, len_inc;
  logic             grant_locked, at_max;
  logic [CNT_W-1:0] cnt_q;
  logic             contend;

  // Grant is forced low during reset so nothing reaches the memory in a reset cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if ((state_q == ARB_LOCK0) && req0) begin
        gnt0 = 1'b1;
      end else if ((state_q == ARB_LOCK1) && req1) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (last_winner_q == REQ_DBG) gnt0 = 1'b1;
        else                          gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = ARB_IDLE;
    len_clr      = 1'b1;
    len_inc      = 1'b0;
    grant_locked = (gnt0 && lock0) || (gnt1 && lock1);
    lock_tgt     = gnt0 ? ARB_LOCK0 : ARB_LOCK1;
    at_max       = (lock_len == LEN_W'(LOCK_MAX - 1));
    if (grant_locked) begin
      if (state_q != lock_tgt) begin
        state_d = lock_tgt;
        len_inc = 1'b1;
      end else if (!at_max) begin
        state_d = lock_tgt;
        len_clr = 1'b0;
        len_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      last_winner_q <= REQ_DBG;
      rd_pending_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= {gnt1 && !we1, gnt0 && !we0};
      if (gnt0)      last_winner_q <= REQ_CPU;
      else if (gnt1) last_winner_q <= REQ_DBG;
    end
  end

  synth_sat_counter #(.W(LEN_W)) u_lock_len (
    .clk (clk),
    .rst (rst),
    .clr (len_clr),
    .inc (len_inc),
    .cnt (lock_len)
  );

  assign contend = (req0 && !gnt0) || (req1 && !gnt1);

  synth_sat_counter #(.W(CNT_W)) u_contention (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (contend),
    .cnt (cnt_q)
  );

  assign mem_wr_ena = (gnt0 && we0) || (gnt1 && we1);
  assign mem_addr   = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_din    = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  assign rvalid0 = rd_pending_q[REQ_CPU] && !rst;
  assign rvalid1 = rd_pending_q[REQ_DBG] && !rst;
  assign rdata0  = rvalid0 ? mem_dout : '0;
  assign rdata1  = rvalid1 ? mem_dout : '0;

  assign contention_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_synth_mem_port_arbiter.sv
// Directed bench for the memory port arbiter: instance a (LOCK_MAX=4) with a write-first memory model,
// instance b (LOCK_MAX=64, CNT_W=4) for counter saturation.
module tb_synth_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wr_ena;
  logic [31:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;
  logic [15:0] contention_cnt;

  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_wr_ena;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_din, b_mem_dout;
  logic [3:0]  b_contention_cnt;

  logic [31:0] mem [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign b_mem_dout = 32'hA5A5_0F0F;

  synth_mem_port_arbiter #(.N(32), .LOCK_MAX(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr_ena(mem_wr_ena), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .contention_cnt(contention_cnt)
  );

  synth_mem_port_arbiter #(.N(32), .LOCK_MAX(64), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(b_gnt0), .gnt1(b_gnt1),
    .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_wr_ena(b_mem_wr_ena), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
    .mem_dout(b_mem_dout), .contention_cnt(b_contention_cnt)
  );

  // Write-first synchronous memory, word-indexed, preloaded during reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4]   <= 32'hDEAD_BEEF;
      mem_dout <= 32'h0;
    end else begin
      if (mem_wr_ena) mem[mem_addr[5:2]] <= mem_din;
      mem_dout <= mem_wr_ena ? mem_din : mem[mem_addr[5:2]];
    end
  end

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    req0 = 1; req1 = 1; we1 = 1; lock0 = 1; addr1 = 32'h44; wdata1 = 32'h99;
    #1;
    n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1); end
    n_checks++; if (mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ena: got %b expected 0", mem_wr_ena); end
    n_checks++; if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin n_fail++; $display("FAIL reset_mux: got addr %h din %h expected 0", mem_addr, mem_din); end
    @(negedge clk); #1;
    n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b expected 00", rvalid0, rvalid1); end
    n_checks++; if (contention_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", contention_cnt); end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    req0 = 1; we0 = 0; addr0 = 32'h0000_0010;
    #1;
    n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_read_gnt: got %b%b expected 10", gnt0, gnt1); end
    n_checks++; if (mem_addr !== 32'h10 || mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL single_read_bus: got addr %h wr %b expected 10 0", mem_addr, mem_wr_ena); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL single_read_rvalid0: got %b expected 1", rvalid0); end
    n_checks++; if (rdata0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_read_rdata0: got %h expected deadbeef", rdata0); end
    n_checks++; if (rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin n_fail++; $display("FAIL single_read_port1: got %b %h expected 0 0", rvalid1, rdata1); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_winner;
    exp_winner = 4'b1010;
    do_reset();
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h14;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (gnt0 !== !exp_winner[i] || gnt1 !== exp_winner[i]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b%b expected winner %0d", i, gnt0, gnt1, exp_winner[i]); end
      n_checks++; if (mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL rr_wr_ena[%0d]: got %b expected 0", i, mem_wr_ena); end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_checks++; if (contention_cnt !== 16'd4) begin n_fail++; $display("FAIL rr_cnt: got %0d expected 4", contention_cnt); end
  endtask

  task automatic test_lock_release();
    logic [5:0] exp_winner;
    exp_winner = 6'b101111;
    do_reset();
    req0 = 1; addr0 = 32'h10;
    #1;
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL lock_prime_gnt0: got %b expected 1", gnt0); end
    @(negedge clk);
    req1 = 1; lock1 = 1; addr1 = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if (gnt0 !== !exp_winner[i] || gnt1 !== exp_winner[i]) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b%b expected winner %0d", i, gnt0, gnt1, exp_winner[i]); end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_checks++; if (contention_cnt !== 16'd6) begin n_fail++; $display("FAIL lock_cnt: got %0d expected 6", contention_cnt); end
  endtask

  task automatic test_write_readback();
    do_reset();
    req1 = 1; we1 = 1; addr1 = 32'h4000_0008; wdata1 = 32'h1234_5678;
    #1;
    n_checks++; if (gnt1 !== 1'b1 || mem_wr_ena !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got gnt1 %b wr %b expected 1 1", gnt1, mem_wr_ena); end
    n_checks++; if (mem_addr !== 32'h4000_0008 || mem_din !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_bus: got %h %h expected 40000008 12345678", mem_addr, mem_din); end
    @(negedge clk);
    idle_inputs();
    req0 = 1; addr0 = 32'h4000_0008;
    #1;
    n_checks++; if (gnt0 !== 1'b1 || mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL rb_gnt: got gnt0 %b wr %b expected 1 0", gnt0, mem_wr_ena); end
    n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b expected 0", rvalid1); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h1234_5678) begin n_fail++; $display("FAIL rb_data: got %b %h expected 1 12345678", rvalid0, rdata0); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req0 = 1; addr0 = 32'h10;
    #1;
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt0: got %b expected 1", gnt0); end
    @(negedge clk);
    rst = 1;
    req1 = 1; we1 = 1; addr1 = 32'h44; wdata1 = 32'h1;
    #1;
    n_checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin n_fail++; $display("FAIL midrst_rvalid0: got %b %h expected 0 0", rvalid0, rdata0); end
    n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt: got %b%b wr %b expected 00 0", gnt0, gnt1, mem_wr_ena); end
    n_checks++; if (mem_addr !== 32'h0 || mem_din !== 32'h0 || contention_cnt !== 16'h0) begin n_fail++; $display("FAIL midrst_outs: got %h %h %0d expected 0", mem_addr, mem_din, contention_cnt); end
    @(negedge clk);
    rst = 0;
    we1 = 0;
    #1;
    n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL midrst_first_win: got %b%b expected 10", gnt0, gnt1); end
    n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_rvalid: got %b expected 0", rvalid0); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    req0 = 1; lock0 = 1; we0 = 0; addr0 = 32'h30; wdata0 = 32'h55;
    req1 = 1; addr1 = 32'h34;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++; if (b_gnt0 !== 1'b1 || b_gnt1 !== 1'b0) begin n_fail++; $display("FAIL sat_gnt[%0d]: got %b%b expected 10", i, b_gnt0, b_gnt1); end
      n_checks++; if (b_mem_addr !== 32'h30 || b_mem_din !== 32'h55 || b_mem_wr_ena !== 1'b0) begin n_fail++; $display("FAIL sat_bus[%0d]: got %h %h %b expected 30 55 0", i, b_mem_addr, b_mem_din, b_mem_wr_ena); end
      n_checks++; if (b_contention_cnt !== ((i < 15) ? 4'(i) : 4'hF)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, b_contention_cnt, (i < 15) ? i : 15); end
      if (i > 0) begin
        n_checks++; if (b_rvalid0 !== 1'b1 || b_rdata0 !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL sat_rd0[%0d]: got %b %h expected 1 a5a50f0f", i, b_rvalid0, b_rdata0); end
      end
      n_checks++; if (b_rvalid1 !== 1'b0 || b_rdata1 !== 32'h0) begin n_fail++; $display("FAIL sat_rd1[%0d]: got %b %h expected 0 0", i, b_rvalid1, b_rdata1); end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_checks++; if (b_contention_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_final: got %0d expected 15", b_contention_cnt); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_release();
    test_write_readback();
    test_reset_mid_read();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_mem_port_arbiter.md
Name: synth_mem_port_arbiter

Overview:
- Shares one bus of the synthesizable dual-port instruction/data memory between two requesters: requester 0 (CPU load/store path) and requester 1 (debug/boot loader or IO).
- Per-cycle round-robin arbitration, with an optional bounded lock for atomic multi-cycle sequences such as read-modify-write or burst program load.
- Tracks the memory's 1-cycle synchronous read latency and returns read data to the correct requester.
- Sits between the requesters and the memory's wr_ena/addr/din/dout bus.

Parameters:
- N, 32, data and address bus width.
- LOCK_MAX, 8, maximum consecutive locked grant cycles before a forced release (≥2).
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req0, req1  in  1  access request.
- we0, we1  in  1  1 = write, 0 = read; sampled when granted.
- lock0, lock1  in  1  request to keep the grant next cycle.
- addr0, addr1  in  N  byte address, passed through unchanged.
- wdata0, wdata1  in  N  write data.
- gnt0, gnt1  out  1  combinational grant; access is performed this cycle.
- rvalid0, rvalid1  out  1  read data valid (one cycle after the granted read).
- rdata0, rdata1  out  N  read data.
- mem_wr_ena  out  1  to memory wr_ena.
- mem_addr  out  N  to memory addr.
- mem_din  out  N  to memory din.
- mem_dout  in  N  from memory dout, valid one cycle after the address.
- contention_cnt  out  CNT_W  saturating count of cycles a requester was denied.

Behaviour:
- FSM states: IDLE, LOCK0, LOCK1. Registers: last_winner (1 bit), lock_len, rd_pending[1:0], contention_cnt.
- Reset (synchronous, while rst = 1):
  - state = IDLE; last_winner = 1, so requester 0 wins the first tie.
  - lock_len = 0; rd_pending = 0; contention_cnt = 0.
  - All outputs 0. No memory write can occur during a reset cycle, and gnt is forced to 0.
- Arbitration in IDLE:
  - Exactly one requester → grant it.
  - Both requesting → grant the one that is not last_winner.
  - None requesting → no grant.
- Arbitration in LOCKk:
  - Grant k if req_k = 1, even if the other requester is requesting.
  - If req_k = 0, arbitrate as in IDLE.
- At most one of gnt0/gnt1 is high in any cycle.
- Mux to memory:
  - mem_addr = addr of the granted requester; mem_din = its wdata; mem_wr_ena = gnt & we.
  - With no grant: mem_wr_ena = 0, mem_addr = 0, mem_din = 0.
- Read return:
  - rd_pending[k] <= gnt_k & ~we_k.
  - rvalid_k = rd_pending[k]; rdata_k = mem_dout when rvalid_k, else 0.
  - Read latency is exactly 1 cycle after the grant. Back-to-back reads from either requester are supported every cycle.
- Writes have no rvalid; gnt is the write acknowledge. A granted write followed by a read of the same address the next cycle returns the new data, because the memory is write-first per port.
- last_winner updates to k on every cycle where gnt_k = 1.
- Lock transitions:
  - Entry: if gnt_k & lock_k & req_k, then next state = LOCKk and lock_len increments (lock_len = 1 after the first locked grant).
  - Forced release: if lock_len == LOCK_MAX-1 when lock_k is asserted, next state = IDLE and lock_len = 0. The next cycle arbitrates normally, and since last_winner = k the other requester wins if it is requesting.
  - Normal exit: lock_k = 0 or req_k = 0 → IDLE, lock_len = 0.
  - A lock request from a non-granted requester is ignored.
- contention_cnt: increments when (req0 & ~gnt0) | (req1 & ~gnt1); saturates at all-ones; never wraps.
- Reset mid-operation: a pending read's rvalid is suppressed, lock is dropped, and no stale grant reaches the next cycle.

Decomposition:
- Shared package: FSM state encodings (ARB_IDLE, ARB_LOCK0, ARB_LOCK1) and the requester index constants (REQ_CPU = 0, REQ_DBG = 1).
- One natural sub-module: synth_sat_counter (parameterized width, increment enable, synchronous reset), used for contention_cnt and reusable for lock_len.

Test Plan:
- Reset then single read: req0 = 1, we0 = 0, addr0 = 0x0000_0010 with memory word 4 = 0xDEADBEEF → gnt0 = 1 in the same cycle; rvalid0 = 1 and rdata0 = 0xDEADBEEF the next cycle; rvalid1 stays 0.
- Tie and round-robin: req0 = req1 = 1 held for 4 cycles, no locks → grants go 0, 1, 0, 1; contention_cnt = 4 afterwards; mem_wr_ena never high for reads.
- Lock with forced release (LOCK_MAX = 4): req1 + lock1 held, req0 held → gnt1 for 4 consecutive cycles, then gnt0 on the 5th; contention_cnt increments every cycle req0 is denied.
- Write then read-back: requester 1 writes 0x1234_5678 to 0x4000_0008 (instruction space) → mem_wr_ena = 1, mem_addr = 0x4000_0008 that cycle; requester 0 reads 0x4000_0008 the next cycle → rdata0 = 0x1234_5678 one cycle later.
- Reset mid-read: grant a read to requester 0, assert rst in the following cycle → rvalid0 = 0, all outputs 0, state IDLE; after rst falls, with both requesting, requester 0 wins first.
- Saturation (CNT_W = 4): 20 cycles of requester 1 denied (requester 0 locked, LOCK_MAX large) → contention_cnt holds at 0xF.
